// File: rtl/spin_speed_selector_pkg.sv
// Speed table, per-mode default/maximum index tables and wash-mode names.
package spin_pkg;

    localparam int unsigned NUM_MODES = 8;

    localparam int unsigned COTTON     = 0;
    localparam int unsigned SYNTH      = 1;
    localparam int unsigned DELICATE   = 2;
    localparam int unsigned WOOL       = 3;
    localparam int unsigned QUICK      = 4;
    localparam int unsigned RINSE_SPIN = 5;
    localparam int unsigned SPIN_ONLY  = 6;
    localparam int unsigned DRAIN      = 7;

    // Spin speed in rpm for each table index.
    function automatic int unsigned speed_lut(input int unsigned i);
        case (i)
            32'd0:   return 0;
            32'd1:   return 200;
            32'd2:   return 400;
            32'd3:   return 600;
            32'd4:   return 800;
            32'd5:   return 1000;
            32'd6:   return 1200;
            32'd7:   return 1400;
            default: return 0;
        endcase
    endfunction

    // Index loaded when a wash mode is selected.
    function automatic int unsigned def_idx(input int unsigned mode);
        case (mode)
            COTTON:     return 5;
            SYNTH:      return 4;
            DELICATE:   return 2;
            WOOL:       return 3;
            QUICK:      return 4;
            RINSE_SPIN: return 6;
            SPIN_ONLY:  return 7;
            DRAIN:      return 0;
            default:    return 0;
        endcase
    endfunction

    // Highest index a wash mode may step up to.
    function automatic int unsigned max_idx(input int unsigned mode);
        case (mode)
            COTTON:     return 7;
            SYNTH:      return 6;
            DELICATE:   return 3;
            WOOL:       return 4;
            QUICK:      return 7;
            RINSE_SPIN: return 7;
            SPIN_ONLY:  return 7;
            DRAIN:      return 0;
            default:    return 0;
        endcase
    endfunction

endpackage

// File: rtl/spin_ramp.sv
// Slews the motor speed command toward a target by a fixed step per tick.
module spin_ramp #(
    parameter int unsigned SPEED_W   = 11,
    parameter int unsigned RAMP_STEP = 100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SPEED_W-1:0] target,
    input  logic               ramp_tick,
    output logic [SPEED_W-1:0] actual_spin_speed,
    output logic               at_speed
);

    localparam int unsigned EXT_W = SPEED_W + 1;

    logic [EXT_W-1:0]   act_x;
    logic [EXT_W-1:0]   tgt_x;
    logic [EXT_W-1:0]   step_x;
    logic [EXT_W-1:0]   up_x;
    logic [SPEED_W-1:0] actual_d;

    // One extra bit so the step arithmetic can neither overflow nor underflow.
    assign act_x  = {1'b0, actual_spin_speed};
    assign tgt_x  = {1'b0, target};
    assign step_x = EXT_W'(RAMP_STEP);
    assign up_x   = act_x + step_x;

    // Next speed: move one step toward the target, clamping so it never overshoots.
    always_comb begin
        actual_d = actual_spin_speed;
        if (ramp_tick) begin
            if (act_x < tgt_x) begin
                actual_d = (up_x >= tgt_x) ? target : SPEED_W'(up_x);
            end else if (act_x > tgt_x) begin
                actual_d = (act_x >= tgt_x + step_x) ? SPEED_W'(act_x - step_x) : target;
            end
        end
    end

    // Speed command register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            actual_spin_speed <= '0;
        end else begin
            actual_spin_speed <= actual_d;
        end
    end

    assign at_speed = (actual_spin_speed == target);

endmodule

// File: rtl/spin_speed_selector.sv
// Per-mode spin-speed selection with button stepping, lock and motor ramp.
module spin_speed_selector
    import spin_pkg::*;
#(
    parameter int unsigned MODE_W     = 3,
    parameter int unsigned SPEED_W    = 11,
    parameter int unsigned NUM_LEVELS = 8,
    parameter int unsigned IDX_W      = 3,
    parameter int unsigned RAMP_STEP  = 100,
    parameter int unsigned WRAP       = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [MODE_W-1:0]  wash_mode,
    input  logic               increment,
    input  logic               decrement,
    input  logic               lock,
    input  logic               motor_en,
    input  logic               ramp_tick,
    output logic [SPEED_W-1:0] selected_spin_speed,
    output logic [SPEED_W-1:0] actual_spin_speed,
    output logic               at_speed
);

    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_d;
    logic [MODE_W-1:0]  mode_q;
    logic [MODE_W-1:0]  mode_d;
    logic               loaded;
    logic               loaded_d;
    logic               inc_q;
    logic               dec_q;
    logic               inc_p;
    logic               dec_p;
    logic [IDX_W-1:0]   def_w;
    logic [IDX_W-1:0]   max_w;
    logic [SPEED_W-1:0] target;

    assign inc_p = increment & ~inc_q;
    assign dec_p = decrement & ~dec_q;
    assign def_w = IDX_W'(def_idx(32'(wash_mode)));
    assign max_w = IDX_W'(max_idx(32'(mode_q)));

    // Next index: default load first, then lock, then button steps.
    always_comb begin
        idx_d    = idx;
        mode_d   = mode_q;
        loaded_d = loaded;
        if (!loaded || (!lock && (wash_mode != mode_q))) begin
            idx_d    = def_w;
            mode_d   = wash_mode;
            loaded_d = 1'b1;
        end else if (lock) begin
            idx_d = idx;
        end else if (inc_p && dec_p) begin
            idx_d = idx;
        end else if (inc_p) begin
            if (idx < max_w) begin
                idx_d = idx + IDX_W'(1);
            end else if (WRAP != 0) begin
                idx_d = '0;
            end
        end else if (dec_p) begin
            if (idx != '0) begin
                idx_d = idx - IDX_W'(1);
            end else if (WRAP != 0) begin
                idx_d = max_w;
            end
        end
    end

    // Selection state and button history; history updates even while locked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx    <= '0;
            mode_q <= '0;
            loaded <= 1'b0;
            inc_q  <= 1'b0;
            dec_q  <= 1'b0;
        end else begin
            idx    <= idx_d;
            mode_q <= mode_d;
            loaded <= loaded_d;
            inc_q  <= increment;
            dec_q  <= decrement;
        end
    end

    // Table decode of the held index; out-of-table indices read as stopped.
    assign selected_spin_speed = (32'(idx) < NUM_LEVELS) ? SPEED_W'(speed_lut(32'(idx))) : '0;
    assign target              = motor_en ? selected_spin_speed : '0;

    spin_ramp #(
        .SPEED_W   (SPEED_W),
        .RAMP_STEP (RAMP_STEP)
    ) u_ramp (
        .clk               (clk),
        .reset             (reset),
        .target            (target),
        .ramp_tick         (ramp_tick),
        .actual_spin_speed (actual_spin_speed),
        .at_speed          (at_speed)
    );

endmodule

// File: tb/tb_spin_speed_selector.sv
// Bench: saturating and wrapping selectors on shared stimulus, checked against a behavioural model.
module tb_spin_speed_selector;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  wash_mode = 3'd0;
    logic        increment = 1'b0;
    logic        decrement = 1'b0;
    logic        lock = 1'b0;
    logic        motor_en = 1'b0;
    logic        ramp_tick = 1'b0;

    logic [10:0] sel0, act0, sel1, act1;
    logic        at0, at1;

    int checks = 0;
    int errors = 0;

    // Behavioural reference: table lookups and integer ramp arithmetic.
    int speed_tab [8] = '{0, 200, 400, 600, 800, 1000, 1200, 1400};
    int def_tab   [8] = '{5, 4, 2, 3, 4, 6, 7, 0};
    int max_tab   [8] = '{7, 6, 3, 4, 7, 7, 7, 0};
    int m_idx  [2];
    int m_mode [2];
    int m_act  [2];
    bit m_loaded [2];
    bit m_inc, m_dec;

    always #5 clk = ~clk;

    spin_speed_selector #(.WRAP(0)) u_sat (
        .clk(clk), .reset(reset), .wash_mode(wash_mode),
        .increment(increment), .decrement(decrement), .lock(lock),
        .motor_en(motor_en), .ramp_tick(ramp_tick),
        .selected_spin_speed(sel0), .actual_spin_speed(act0), .at_speed(at0)
    );

    spin_speed_selector #(.WRAP(1)) u_wrap (
        .clk(clk), .reset(reset), .wash_mode(wash_mode),
        .increment(increment), .decrement(decrement), .lock(lock),
        .motor_en(motor_en), .ramp_tick(ramp_tick),
        .selected_spin_speed(sel1), .actual_spin_speed(act1), .at_speed(at1)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_idx[k] = 0; m_mode[k] = 0; m_act[k] = 0; m_loaded[k] = 0;
        end
        m_inc = 0; m_dec = 0;
    endtask

    function automatic int model_target(input int k);
        return motor_en ? speed_tab[m_idx[k]] : 0;
    endfunction

    // One clock edge of the reference, using the inputs present before the edge.
    task automatic model_edge();
        bit ip, dp;
        int tgt, mx;
        if (reset) begin
            model_reset();
            return;
        end
        ip = increment && !m_inc;
        dp = decrement && !m_dec;
        for (int k = 0; k < 2; k++) begin
            tgt = model_target(k);
            if (ramp_tick) begin
                if (m_act[k] < tgt)      m_act[k] = (m_act[k] + 100 < tgt) ? m_act[k] + 100 : tgt;
                else if (m_act[k] > tgt) m_act[k] = (m_act[k] - 100 > tgt) ? m_act[k] - 100 : tgt;
            end
            mx = max_tab[m_mode[k]];
            if (!m_loaded[k] || (!lock && int'(wash_mode) != m_mode[k])) begin
                m_mode[k]   = int'(wash_mode);
                m_idx[k]    = def_tab[m_mode[k]];
                m_loaded[k] = 1;
            end else if (!lock && !(ip && dp)) begin
                if (ip)      m_idx[k] = (m_idx[k] < mx) ? m_idx[k] + 1 : ((k == 1) ? 0 : m_idx[k]);
                else if (dp) m_idx[k] = (m_idx[k] > 0) ? m_idx[k] - 1 : ((k == 1) ? mx : m_idx[k]);
            end
        end
        m_inc = increment;
        m_dec = decrement;
    endtask

    task automatic compare_all();
        check("model_sel0", int'(sel0), speed_tab[m_idx[0]]);
        check("model_act0", int'(act0), m_act[0]);
        check("model_at0",  int'(at0),  int'(m_act[0] == model_target(0)));
        check("model_sel1", int'(sel1), speed_tab[m_idx[1]]);
        check("model_act1", int'(act1), m_act[1]);
        check("model_at1",  int'(at1),  int'(m_act[1] == model_target(1)));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic press(input bit inc, input bit dec);
        increment = inc; decrement = dec;
        step();
        increment = 0; decrement = 0;
        step();
    endtask

    task automatic tick();
        ramp_tick = 1;
        step();
        ramp_tick = 0;
    endtask

    task automatic idle3();
        step(); step(); step();
    endtask

    task automatic do_reset(input int mode);
        reset = 1; model_reset();
        wash_mode = 3'(mode); lock = 0; increment = 0; decrement = 0;
        ramp_tick = 0; motor_en = 0;
        step();
        reset = 0;
        step();
    endtask

    initial begin
        int exp_sweep [8] = '{1000, 800, 400, 600, 800, 1200, 1400, 0};
        int exp_dn    [5] = '{600, 400, 200, 0, 0};
        model_reset();
        wash_mode = 3'd3;
        @(negedge clk);
        #1;
        check("rst_sel", int'(sel0), 0);
        check("rst_act", int'(act0), 0);
        check("rst_at",  int'(at0),  1);

        // Mode defaults.
        do_reset(3);
        check("wool_default", int'(sel0), 600);
        for (int m = 0; m < 8; m++) begin
            wash_mode = 3'(m);
            step();
            check($sformatf("sweep_m%0d", m), int'(sel0), exp_sweep[m]);
            step();
        end

        // Saturating limits and held button.
        do_reset(3);
        press(1, 0);
        check("sat_up", int'(sel0), 800);
        press(1, 0);
        check("sat_up_max", int'(sel0), 800);
        increment = 1;
        for (int i = 0; i < 5; i++) step();
        increment = 0;
        step();
        check("sat_hold", int'(sel0), 800);
        for (int i = 0; i < 5; i++) begin
            press(0, 1);
            check($sformatf("sat_dn%0d", i), int'(sel0), exp_dn[i]);
        end

        // Wrapping limits and simultaneous edges.
        do_reset(3);
        press(1, 0);
        check("wrap_up", int'(sel1), 800);
        press(1, 0);
        check("wrap_to_0", int'(sel1), 0);
        press(0, 1);
        check("wrap_to_max", int'(sel1), 800);
        press(1, 1);
        check("wrap_both", int'(sel1), 800);

        // Lock freezes selection; deferred mode change, no press replay.
        do_reset(3);
        lock = 1; wash_mode = 3'd0;
        step();
        press(1, 0);
        check("lock_hold0", int'(sel0), 600);
        check("lock_hold1", int'(sel1), 600);
        lock = 0;
        step();
        check("unlock_load", int'(sel0), 1000);
        step();
        check("no_replay", int'(sel0), 1000);

        // Ramp up to 600, retarget to 400, then stop.
        do_reset(3);
        motor_en = 1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("ramp_up%0d", i), int'(act0), 100 * i);
            check($sformatf("ramp_at%0d", i), int'(at0), int'(i == 6));
            idle3();
        end
        press(0, 1);
        check("retarget", int'(sel0), 400);
        tick();
        check("ramp_dn1", int'(act0), 500);
        idle3();
        tick();
        check("ramp_dn2", int'(act0), 400);
        check("ramp_dn_at", int'(at0), 1);
        idle3();
        motor_en = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("ramp_off%0d", i), int'(act0), 400 - 100 * i);
            idle3();
        end

        // Asynchronous reset mid-ramp.
        wash_mode = 3'd0; motor_en = 1;
        step();
        for (int i = 0; i < 7; i++) begin
            tick();
            idle3();
        end
        check("pre_rst_act", int'(act0), 700);
        #2;
        reset = 1; model_reset();
        #1;
        check("async_act", int'(act0), 0);
        check("async_sel", int'(sel0), 0);
        check("async_at",  int'(at0),  1);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        reset = 0;
        step();
        check("post_rst_sel", int'(sel0), 1000);
        check("post_rst_act", int'(act0), 0);
        idle3();
        check("post_rst_idle", int'(act0), 0);

        // Randomised traffic against the reference.
        for (int c = 0; c < 3000; c++) begin
            increment = ($urandom_range(0, 2) == 0);
            decrement = ($urandom_range(0, 2) == 0);
            ramp_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) wash_mode = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) lock = ~lock;
            if ($urandom_range(0, 29) == 0) motor_en = ~motor_en;
            if ($urandom_range(0, 299) == 0) begin
                reset = 1; model_reset();
            end else begin
                reset = 0;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spin_speed_selector.md
Name: spin_speed_selector

Overview:
Parametrised successor to the spin-speed incrementor LUT. It holds a per-wash-mode spin-speed index and steps it up or down on debounced button presses, which are edge-detected so one press gives exactly one step. Each mode has its own default and maximum speed. A wrap or saturate option sets the behaviour at the limits. A lock freezes the selection during a running cycle. A ramp generator slews the actual motor speed toward the selected speed, one step per ramp tick. It sits between the front-panel/mode controller and the motor drive.

Parameters:
MODE_W, 3, width of wash_mode; the number of modes is 2**MODE_W.
SPEED_W, 11, width of speed values in rpm.
NUM_LEVELS, 8, number of speed-table entries.
IDX_W, 3, index width; must satisfy 2**IDX_W >= NUM_LEVELS.
RAMP_STEP, 100, rpm change per ramp_tick.
WRAP, 0, limit behaviour: 0 = saturate at the limits; 1 = wrap from max to 0 and from 0 to max.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high; clears all state
wash_mode  in  MODE_W  selected wash programme
increment  in  1  level button; each rising edge is one up-step
decrement  in  1  level button; each rising edge is one down-step
lock  in  1  1 = cycle running; mode changes and button presses are ignored
motor_en  in  1  1 = ramp toward the selected speed; 0 = ramp toward 0
ramp_tick  in  1  single-cycle slew strobe
selected_spin_speed  out  SPEED_W  SPEED_LUT[idx]
actual_spin_speed  out  SPEED_W  ramped motor speed command
at_speed  out  1  actual_spin_speed equals the ramp target

Behaviour:
- Reset values:
  - idx=0, mode_q=0, loaded=0, inc_q=dec_q=0.
  - selected_spin_speed=0, actual_spin_speed=0, at_speed=1.
- Edge detect: inc_p = increment & ~inc_q; dec_p = decrement & ~dec_q. inc_q and dec_q register every cycle, including while locked.
- idx update, evaluated at each clk edge. The first matching rule below applies:
  1. Default load: if ~loaded, or (~lock and wash_mode != mode_q): idx <= DEF_IDX[wash_mode], mode_q <= wash_mode, loaded <= 1. Any button edges in the same cycle are dropped. The first load after reset happens even if lock=1.
  2. Locked: if lock=1, idx holds. A mode change made while locked is applied on the first cycle after lock falls.
  3. Both edges: if inc_p and dec_p are both set, idx holds.
  4. Up-step: on inc_p, if idx < MAX_IDX[mode_q] then idx+1; else WRAP ? 0 : hold.
  5. Down-step: on dec_p, if idx > 0 then idx-1; else WRAP ? MAX_IDX[mode_q] : hold.
- Held button: no repeat.
- Output timing: selected_spin_speed is a combinational LUT decode of the idx register. Latency is one clock from an event to the output.
- Ramp target: target = motor_en ? selected_spin_speed : 0.
- Ramp update on ramp_tick:
  - If actual < target: actual <= min(actual+RAMP_STEP, target).
  - If actual > target: actual <= max(actual-RAMP_STEP, target).
  - Otherwise actual holds.
- Ramp arithmetic: computed in SPEED_W+1 bits so it cannot overflow or underflow. Actual never overshoots the target.
- Mid-ramp changes: a target change takes effect on the next tick; there is no reset of the ramp.
- at_speed = (actual == target), combinational.
- Reset mid-operation: everything returns to its reset values immediately, asynchronously. After release, the default load occurs on the first clk edge.

Decomposition:
- Package spin_pkg:
  - SPEED_LUT = {0,200,400,600,800,1000,1200,1400}.
  - DEF_IDX per mode = {5,4,2,3,4,6,7,0}.
  - MAX_IDX per mode = {7,6,3,4,7,7,7,0}.
  - Mode localparams: COTTON, SYNTH, DELICATE, WOOL, QUICK, RINSE_SPIN, SPIN_ONLY, DRAIN.
- Sub-module spin_ramp (params SPEED_W, RAMP_STEP):
  - Inputs: clk, reset, target, ramp_tick.
  - Outputs: actual_spin_speed, at_speed.

Test Plan:
- Reset, WOOL (mode 3), release reset -> after 1 clk, selected=600. Sweep modes 0..7, each for 2 clks -> 1000, 800, 400, 600, 800, 1200, 1400, 0.
- WRAP=0, WOOL at 600 -> increment press gives 800. Further presses, including a single 5-cycle hold -> stays 800. Decrement x4 -> 600, 400, 200, 0, then 0 again.
- WRAP=1, WOOL at 800, increment press -> 0. Decrement press -> 800. increment and decrement rising in the same cycle -> no change.
- lock=1, change mode to COTTON and press increment -> selected unchanged. Drop lock -> next clk selected=1000. A press made while locked is not replayed.
- motor_en=1, target 600, ramp_tick every 4 clks:
  - actual goes 100, 200, ... 600 over 6 ticks; at_speed rises on the sixth tick.
  - Change target to 400 -> 500, then 400.
  - motor_en=0 -> ramps to 0.
- With actual=700, assert reset asynchronously between edges -> actual=0 and selected=0 immediately. After release, mode default reloads in 1 clk and actual stays 0 until a tick occurs.
